a2d_seq_multi: RTL and testbench

- Parametrised round-robin ADC sequencer. Successor to the fixed 4-channel A2D interface.
- Sequences up to 8 ADC channels through a configurable channel map. Each conversion is a two-transaction command/read exchange on an external 16-bit SPI master handshake.
- Optionally oversamples each channel by 2^OVS_LOG2 and averages the samples.
- Results appear on a flat per-channel register bus with per-update strobes. Conversions are either triggered by nxt or run free in auto mode.

---
 rtl/a2d_seq_multi_if.sv | 11 +
 rtl/a2d_seq_multi.sv | 143 ++++++++++++++
 tb/tb_a2d_seq_multi.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/a2d_seq_multi_if.sv
// SPI master handshake between the ADC sequencer and an external 16-bit SPI master.
// The sequencer is the master side: it issues commands and consumes the returned data.
interface a2d_seq_multi_if;
  logic        spi_wrt;
  logic [15:0] spi_cmd;
  logic        spi_done;
  logic [15:0] spi_rd;

  modport master (output spi_wrt, spi_cmd, input spi_done, spi_rd);
  modport slave  (input spi_wrt, spi_cmd, output spi_done, spi_rd);
endinterface

// File: rtl/a2d_seq_multi.sv
// Round-robin ADC sequencer with optional 2^OVS_LOG2 oversampling and a per-slot result bus.
// Optional low-threshold alarm on one slot is enabled with the A2D_ALARM_EN macro.
module a2d_seq_multi #(
  parameter int          NUM_CH   = 4,
  parameter logic [23:0] CH_MAP   = 24'o76540,
  parameter int          DATA_W   = 12,
  parameter int          OVS_LOG2 = 0
`ifdef A2D_ALARM_EN
  , parameter int        ALARM_SLOT = NUM_CH - 1
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     nxt,
  input  logic                     auto,
  a2d_seq_multi_if.master          spi,
  output logic [NUM_CH*DATA_W-1:0] result,
  output logic                     upd,
  output logic [2:0]               upd_idx,
  output logic                     busy
`ifdef A2D_ALARM_EN
  , input  logic [DATA_W-1:0]      thresh
  , output logic                   alarm
`endif
);

  localparam int         ACC_W    = DATA_W + OVS_LOG2;
  localparam int         CNT_W    = (OVS_LOG2 > 0) ? OVS_LOG2 : 1;
  localparam logic [2:0] LAST_SEL = 3'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << OVS_LOG2) - 1);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_GAP, S_RD, S_UPD} state_t;

  state_t                   state_q, state_d;
  logic [2:0]               sel_q, sel_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [ACC_W-1:0]         acc_q, acc_d;
  logic [NUM_CH*DATA_W-1:0] result_q, result_d;
  logic [2:0]               upd_idx_q, upd_idx_d;
  logic [DATA_W-1:0]        avg;
  logic                     wrt_c, upd_c;
`ifdef A2D_ALARM_EN
  logic                     alarm_q, alarm_d;
`endif

  assign avg = DATA_W'(acc_q >> OVS_LOG2);

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    result_d  = result_q;
    upd_idx_d = upd_idx_q;
    wrt_c     = 1'b0;
    upd_c     = 1'b0;
`ifdef A2D_ALARM_EN
    alarm_d   = alarm_q;
`endif
    case (state_q)
      S_IDLE: if (nxt || auto) begin
        wrt_c   = 1'b1;
        state_d = S_CMD;
      end
      S_CMD: if (spi.spi_done) state_d = S_GAP;
      S_GAP: begin
        wrt_c   = 1'b1;
        state_d = S_RD;
      end
      S_RD: if (spi.spi_done) begin
        acc_d = acc_q + ACC_W'(spi.spi_rd[DATA_W-1:0]);
        if (cnt_q == LAST_CNT) begin
          state_d = S_UPD;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          wrt_c   = 1'b1;
          state_d = S_CMD;
        end
      end
      S_UPD: begin
        result_d[DATA_W*sel_q +: DATA_W] = avg;
        upd_c     = 1'b1;
        upd_idx_d = sel_q;
        acc_d     = '0;
        cnt_d     = '0;
        sel_d     = (sel_q == LAST_SEL) ? 3'd0 : sel_q + 3'd1;
`ifdef A2D_ALARM_EN
        if (sel_q == 3'(ALARM_SLOT)) alarm_d = (avg < thresh);
`endif
        if (auto) begin
          wrt_c   = 1'b1;
          state_d = S_CMD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset clears the result bank too.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      upd_idx_q <= '0;
`ifdef A2D_ALARM_EN
      alarm_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      upd_idx_q <= upd_idx_d;
`ifdef A2D_ALARM_EN
      alarm_q   <= alarm_d;
`endif
    end
  end

  // The command follows sel_d so that the auto-chained pulse in UPD already targets the new slot.
  assign spi.spi_cmd = {2'b00, CH_MAP[3*sel_d +: 3], 11'h000};
  assign spi.spi_wrt = wrt_c && !rst;
  assign upd         = upd_c && !rst;
  assign upd_idx     = upd ? sel_q : upd_idx_q;
  assign busy        = (state_q != S_IDLE) && !rst;
  assign result      = result_q;
`ifdef A2D_ALARM_EN
  assign alarm       = alarm_q;
`endif

  if (DATA_W < 16) begin : g_rd_hi
    logic unused_rd_hi;
    assign unused_rd_hi = ^spi.spi_rd[15:DATA_W];
  end

endmodule

// File: tb/tb_a2d_seq_multi.sv
// Directed bench for a2d_seq_multi: default 4-slot instance plus a 2-slot 4x-oversampling instance.
module tb_a2d_seq_multi;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic nxt = 1'b0, auto = 1'b0, nxt_b = 1'b0;
  logic stray_done = 1'b0;
  logic [11:0] alarm_rd = 12'h900;
  logic [11:0] thresh = 12'h800;

  logic [47:0] result;
  logic        upd, busy;
  logic [2:0]  upd_idx;
  logic [23:0] result_b;
  logic        upd_b, busy_b;
  logic [2:0]  upd_idx_b;
`ifdef A2D_ALARM_EN
  logic        alarm, alarm_b;
`endif

  int n_cmp = 0, n_bad = 0;
  int wrt_cnt = 0, upd_cnt = 0, wrt_cnt_b = 0, upd_cnt_b = 0;
  logic [15:0] last_cmd = '0;
  int ovs_k = 0;
  logic [15:0] ovs_samp [4] = '{16'd100, 16'd101, 16'd102, 16'd104};

  always #5 clk = ~clk;

  a2d_seq_multi_if spi_a ();
  a2d_seq_multi_if spi_b ();

  a2d_seq_multi u_dut (
    .clk(clk), .rst(rst), .nxt(nxt), .auto(auto), .spi(spi_a),
    .result(result), .upd(upd), .upd_idx(upd_idx), .busy(busy)
`ifdef A2D_ALARM_EN
    , .thresh(thresh), .alarm(alarm)
`endif
  );

  a2d_seq_multi #(.NUM_CH(2), .OVS_LOG2(2)) u_ovs (
    .clk(clk), .rst(rst), .nxt(nxt_b), .auto(1'b0), .spi(spi_b),
    .result(result_b), .upd(upd_b), .upd_idx(upd_idx_b), .busy(busy_b)
`ifdef A2D_ALARM_EN
    , .thresh(thresh), .alarm(alarm_b)
`endif
  );

  function automatic logic [15:0] rd_for(input logic [2:0] addr);
    case (addr)
      3'd0:    return 16'h0ABC;
      3'd4:    return 16'h0123;
      3'd5:    return 16'h0555;
      3'd6:    return {4'h0, alarm_rd};
      default: return 16'h0FFF;
    endcase
  endfunction

  // SPI master models: done one cycle after each wrt, data chosen by the commanded address.
  always @(posedge clk) begin
    spi_a.spi_done <= spi_a.spi_wrt | stray_done;
    if (spi_a.spi_wrt) spi_a.spi_rd <= rd_for(spi_a.spi_cmd[13:11]);
    spi_b.spi_done <= spi_b.spi_wrt;
    if (spi_b.spi_wrt) begin
      spi_b.spi_rd <= ovs_samp[(ovs_k >> 1) & 3];
      ovs_k <= ovs_k + 1;
    end
  end

  always @(posedge clk) begin
    if (spi_a.spi_wrt) begin wrt_cnt++; last_cmd = spi_a.spi_cmd; end
    if (upd) upd_cnt++;
    if (spi_b.spi_wrt) wrt_cnt_b++;
    if (upd_b) upd_cnt_b++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse nxt for one cycle and wait for upd; cyc counts cycles from the nxt cycle through the upd cycle.
  task automatic do_nxt(output int cyc, output int wrts);
    int w0;
    w0 = wrt_cnt;
    @(negedge clk); nxt = 1'b1; cyc = 1;
    @(negedge clk); nxt = 1'b0; cyc++;
    while (!upd && cyc < 100) begin @(negedge clk); cyc++; end
    wrts = wrt_cnt - w0;
  endtask

  task automatic slot_update(input string tag, input logic [2:0] idx, input logic [11:0] val);
    int cyc, wrts;
    do_nxt(cyc, wrts);
    check({tag, "_latency"}, cyc, 5);
    check({tag, "_wrt_pulses"}, wrts, 2);
    check({tag, "_upd_idx"}, upd_idx, idx);
    @(negedge clk);
    check({tag, "_result"}, result[12*idx +: 12], val);
  endtask

  initial begin
    int cyc, wrts, w0, u0, seen, k;
    bit dropped;
    logic [2:0] exp_seq [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_result", result, 48'h0);
    check("rst_upd_idx", upd_idx, 0);
    check("rst_upd", upd, 0);
    check("rst_wrt", spi_a.spi_wrt, 0);

    slot_update("slot0", 3'd0, 12'hABC);
    check("slot0_cmd", last_cmd, 16'h0000);
    slot_update("slot1", 3'd1, 12'h123);
    check("slot1_cmd", last_cmd, 16'h2000);
    check("slot1_keeps_slot0", result[11:0], 12'hABC);

    // Reset while slot 2 is in its read transaction.
    w0 = wrt_cnt;
    @(negedge clk); nxt = 1'b1;
    @(negedge clk); nxt = 1'b0;
    k = 0;
    while (wrt_cnt - w0 < 2 && k < 50) begin @(negedge clk); k++; end
    check("midrd_reached", k < 50, 1);
    check("midrd_cmd", last_cmd, 16'h2800);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("midrd_busy", busy, 0);
    check("midrd_result", result, 48'h0);
    check("midrd_upd_idx", upd_idx, 0);
    w0 = wrt_cnt; u0 = upd_cnt;
    @(negedge clk); stray_done = 1'b1;
    @(negedge clk); stray_done = 1'b0;
    repeat (5) @(negedge clk);
    check("stray_no_wrt", wrt_cnt - w0, 0);
    check("stray_no_upd", upd_cnt - u0, 0);

    // nxt re-asserted mid-conversion must not queue another update.
    u0 = upd_cnt;
    @(negedge clk); nxt = 1'b1;
    @(negedge clk); nxt = 1'b0;
    @(negedge clk); nxt = 1'b1;
    @(negedge clk); nxt = 1'b0;
    repeat (12) @(negedge clk);
    check("busy_nxt_one_upd", upd_cnt - u0, 1);
    check("busy_nxt_idx", upd_idx, 0);
    check("busy_nxt_slot0", result[11:0], 12'hABC);
    check("busy_nxt_slot1_kept", result[23:12], 12'h000);
    slot_update("after_busy", 3'd1, 12'h123);

    // Free-running sequence from slot 0.
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); auto = 1'b1;
    seen = 0; k = 0; dropped = 1'b0;
    while (seen < 5 && k < 200) begin
      @(negedge clk); k++;
      if (!busy) dropped = 1'b1;
      if (upd) begin
        check($sformatf("auto_idx%0d", seen), upd_idx, exp_seq[seen]);
        seen++;
        if (seen == 5) auto = 1'b0;
      end
    end
    auto = 1'b0;
    check("auto_count", seen, 5);
    check("auto_busy_held", dropped, 0);
    @(negedge clk);
    check("auto_slot2", result[35:24], 12'h555);
    check("auto_slot3", result[47:36], 12'h900);
    check("auto_stops", busy, 0);

`ifdef A2D_ALARM_EN
    check("alarm_after_auto", alarm, 0);
    alarm_rd = 12'h7FF;
    slot_update("al_s1", 3'd1, 12'h123);
    slot_update("al_s2", 3'd2, 12'h555);
    check("alarm_hold_other", alarm, 0);
    slot_update("al_s3a", 3'd3, 12'h7FF);
    check("alarm_set", alarm, 1);
    alarm_rd = 12'h800;
    slot_update("al_s0", 3'd0, 12'hABC);
    check("alarm_hold_set", alarm, 1);
    slot_update("al_s1b", 3'd1, 12'h123);
    slot_update("al_s2b", 3'd2, 12'h555);
    slot_update("al_s3b", 3'd3, 12'h800);
    check("alarm_clear", alarm, 0);
`endif

    // Oversampling instance: four samples averaged into one update.
    w0 = wrt_cnt_b;
    @(negedge clk); nxt_b = 1'b1;
    @(negedge clk); nxt_b = 1'b0;
    k = 0;
    while (!upd_b && k < 200) begin @(negedge clk); k++; end
    check("ovs_upd_seen", upd_b, 1);
    check("ovs_wrt_pulses", wrt_cnt_b - w0, 8);
    check("ovs_upd_idx", upd_idx_b, 0);
    repeat (5) @(negedge clk);
    check("ovs_result", result_b[11:0], 12'd101);
    check("ovs_one_upd", upd_cnt_b, 1);
    check("ovs_slot1_kept", result_b[23:12], 12'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
